// File: rtl/sine_pkg.sv
// Definitions shared by the sine sequencer and the quarter-wave sample memory.
package sine_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    PEAK   = 2'd0,
    FALL   = 2'd1,
    TROUGH = 2'd2,
    RISE   = 2'd3
  } quadrant_t;

endpackage

// File: rtl/sine_sequencer_if.sv
// Lookup port between the sine sequencer (master) and the sample memory (slave).
interface sine_sequencer_if;
  import sine_pkg::*;

  logic [ADDR_W-1:0] read_address;
  quadrant_t         read_state;
  logic [DATA_W-1:0] read_data;

  modport master (output read_address, output read_state, input read_data);
  modport slave  (input read_address, input read_state, output read_data);

endinterface

// File: rtl/sine_sequencer_tick_divider.sv
// Sample-period divider: one tick every period+1 enabled cycles.
module tick_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] tick_cnt;

  // Compare with >= so a period shortened below the running count fires at once.
  assign tick = enable && (tick_cnt >= period);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sine_sequencer.sv
// Walks the quarter-wave table through all four quadrants and captures the samples.
// Optional feature macro: SINE_SEQ_PHASE_STEP_EN (adds phase_step address increment).
module sine_sequencer
  import sine_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
`ifdef SINE_SEQ_PHASE_STEP_EN
  input  logic [3:0]           phase_step,
`endif
  sine_sequencer_if.master     mem,
  output logic [DATA_W-1:0]    sample,
  output logic                 sample_valid,
  output logic                 sample_first
);

  logic              tick;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] next_addr;
  quadrant_t         next_state;
  logic              req_d1;
  logic              req_d2;
  logic              first_d1;
  logic              first_d2;

  tick_divider #(.DIV_WIDTH(DIV_WIDTH)) u_tick_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

`ifdef SINE_SEQ_PHASE_STEP_EN
  assign step = ADDR_W'(phase_step);
`else
  assign step = ADDR_W'(1);
`endif

  // The carry out of the 7-bit address is what moves the quadrant on.
  assign addr_sum   = {1'b0, mem.read_address} + {1'b0, step};
  assign next_addr  = addr_sum[ADDR_W-1:0];
  assign next_state = quadrant_t'(mem.read_state + {1'b0, addr_sum[ADDR_W]});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem.read_address <= '0;
      mem.read_state   <= PEAK;
      req_d1           <= 1'b0;
      req_d2           <= 1'b0;
      first_d1         <= 1'b0;
      first_d2         <= 1'b0;
      sample           <= '0;
      sample_valid     <= 1'b0;
      sample_first     <= 1'b0;
    end else begin
      if (tick) begin
        mem.read_address <= next_addr;
        mem.read_state   <= next_state;
      end
      req_d1       <= tick;
      first_d1     <= tick && (next_state == PEAK) && (next_addr < step);
      req_d2       <= req_d1;
      first_d2     <= first_d1;
      // Memory data for the request is valid while req_d2 is high.
      sample_valid <= req_d2;
      sample_first <= req_d2 && first_d2;
      if (req_d2) begin
        sample <= mem.read_data;
      end
    end
  end

endmodule

// File: tb/tb_sine_sequencer.sv
// Scoreboard bench for sine_sequencer with a {state,addr} memory model.
module tb_sine_sequencer;
  import sine_pkg::*;

  typedef struct {
    logic [9:0] data;
    logic       first;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] period;
`ifdef SINE_SEQ_PHASE_STEP_EN
  logic [3:0]  phase_step;
`endif
  logic [9:0]  sample;
  logic        sample_valid;
  logic        sample_first;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  sine_sequencer_if mem_if ();

  sine_sequencer #(.DIV_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .period       (period),
`ifdef SINE_SEQ_PHASE_STEP_EN
    .phase_step   (phase_step),
`endif
    .mem          (mem_if.master),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_first (sample_first)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered, returns {state,addr} so data equals the linear position.
  always @(posedge clk) mem_if.read_data <= {1'b0, mem_if.read_state, mem_if.read_address};

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic void push_exp(input int pos, input bit first);
    exp_t e;
    e.data  = 10'(pos % 512);
    e.first = first;
    exp_q.push_back(e);
  endfunction

  // Monitor: every strobe must match the oldest expected sample.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_strobe: got sample=%0d first=%0b expected no strobe",
                 sample, sample_first);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (sample !== e.data || sample_first !== e.first) begin
          failures++;
          $display("[TB] FAIL sample: got sample=%0d first=%0b expected sample=%0d first=%0b",
                   sample, sample_first, e.data, e.first);
        end
      end
    end
  end

  initial begin
    int valid_cnt, bad_addr, bad_valid, changes, first_v, last_v, exp_addr;
    logic [6:0] prev_addr;

    rst_n  = 1'b0;
    enable = 1'b0;
    period = '0;
`ifdef SINE_SEQ_PHASE_STEP_EN
    phase_step = 4'd0;
`endif
    repeat (3) @(negedge clk);
    check("reset_addr", mem_if.read_address, 0);
    check("reset_state", int'(mem_if.read_state), 0);
    check("reset_sample", sample, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_first", sample_first, 0);

    // period=0: full-rate sweep of all 512 positions
    $display("[TB] full sweep, period=0");
    for (int i = 1; i <= 512; i++) push_exp(i, i == 512);
    rst_n = 1'b1; enable = 1'b1; period = 16'd0;
    valid_cnt = 0;
    for (int k = 1; k <= 514; k++) begin
      @(negedge clk);
      if (k == 2) check("t1_valid_cycle2", sample_valid, 0);
      if (k >= 3) valid_cnt += int'(sample_valid);
      if (k == 512) enable = 1'b0;
    end
    check("t1_valid_continuous", valid_cnt, 512);
    repeat (4) @(negedge clk);
    check("t1_wrap_addr", mem_if.read_address, 0);
    check("t1_wrap_state", int'(mem_if.read_state), 0);

    // period=3: one request every 4 cycles, strobe 2 cycles after the address
    $display("[TB] sweep, period=3");
    for (int i = 1; i <= 512; i++) push_exp(i, i == 512);
    period = 16'd3; enable = 1'b1;
    prev_addr = mem_if.read_address;
    bad_addr = 0; bad_valid = 0; changes = 0; valid_cnt = 0; first_v = -1; last_v = -1;
    for (int k = 1; k <= 2050; k++) begin
      @(negedge clk);
      if (mem_if.read_address != prev_addr) begin
        changes++;
        if (k % 4 != 0) bad_addr++;
      end
      prev_addr = mem_if.read_address;
      if (sample_valid !== ((k >= 6) && (k % 4 == 2))) bad_valid++;
      if (sample_valid === 1'b1) begin
        valid_cnt++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
      if (k == 2048) enable = 1'b0;
    end
    check("t2_addr_timing_errors", bad_addr, 0);
    check("t2_valid_timing_errors", bad_valid, 0);
    check("t2_addr_changes", changes, 512);
    check("t2_valid_count", valid_cnt, 512);
    check("t2_sweep_cycles", last_v - first_v + 4, 2048);
    repeat (3) @(negedge clk);

    // enable dropped right after a tick, frozen for 20 cycles, then resumed
    $display("[TB] enable hold");
    push_exp(1, 1'b0); push_exp(2, 1'b0);
    enable = 1'b1;
    bad_addr = 0; bad_valid = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_addr = (k < 4) ? 0 : (k < 28) ? 1 : 2;
      if (mem_if.read_address != 7'(exp_addr) || mem_if.read_state != PEAK) bad_addr++;
      if (sample_valid !== (k == 6 || k == 30)) bad_valid++;
      if (k == 4 || k == 28) enable = 1'b0;
      if (k == 24) enable = 1'b1;
    end
    check("t3_addr_errors", bad_addr, 0);
    check("t3_valid_errors", bad_valid, 0);

    // period cut from 100 to 5 while tick_cnt=50
    $display("[TB] period change");
    push_exp(3, 1'b0); push_exp(4, 1'b0); push_exp(5, 1'b0);
    period = 16'd100; enable = 1'b1;
    bad_addr = 0; bad_valid = 0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      exp_addr = (k < 51) ? 2 : (k < 57) ? 3 : (k < 63) ? 4 : 5;
      if (mem_if.read_address != 7'(exp_addr)) bad_addr++;
      if (sample_valid !== (k == 53 || k == 59 || k == 65)) bad_valid++;
      if (k == 50) period = 16'd5;
      if (k == 63) enable = 1'b0;
    end
    check("t4_addr_errors", bad_addr, 0);
    check("t4_valid_errors", bad_valid, 0);

    // reset pulse with two requests in flight
    $display("[TB] reset with requests in flight");
    period = 16'd0; enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0;
    check("t5_addr", mem_if.read_address, 0);
    check("t5_state", int'(mem_if.read_state), 0);
    check("t5_sample", sample, 0);
    check("t5_valid", sample_valid, 0);
    check("t5_first", sample_first, 0);
    valid_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      valid_cnt += int'(sample_valid);
    end
    check("t5_no_strobe", valid_cnt, 0);

`ifdef SINE_SEQ_PHASE_STEP_EN
    // phase_step=5 from (PEAK,0): 26 steps reach (FALL,2), 102 reach (RISE,126)
    $display("[TB] phase_step=5");
    for (int n = 1; n <= 103; n++) push_exp(5 * n, n == 103);
    phase_step = 4'd5; enable = 1'b1;
    for (int k = 1; k <= 103; k++) begin
      @(negedge clk);
      if (k == 26) check("t6_fall2", {int'(mem_if.read_state), int'(mem_if.read_address)}, {32'd1, 32'd2});
      if (k == 102) check("t6_rise126", {int'(mem_if.read_state), int'(mem_if.read_address)}, {32'd3, 32'd126});
      if (k == 103) begin
        check("t6_peak3", {int'(mem_if.read_state), int'(mem_if.read_address)}, {32'd0, 32'd3});
        enable = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    for (int n = 1; n <= 3; n++) push_exp(3, 1'b0);
    phase_step = 4'd0; enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) enable = 1'b0;
    end
    check("t6_step0_hold", mem_if.read_address, 3);
    repeat (3) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sine_sequencer.md
# sine_sequencer

- Drives the sample memory's `read_address`/`read_state` lookup port, walking a quarter-wave table through all four quadrants at a programmable sample rate.
- Captures the memory's registered 10-bit output and presents it as a `sample_valid`-qualified stream.
- Sits between the sample memory and the DAC/PWM output stage as the requesting end of the memory lookup interface.

## Interface
Parameters:
- `DIV_WIDTH`, 16, width of the sample-period divider.

Ports:
- `clk`  in  1  system clock. Single clock domain; all logic runs on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  run/hold.
- `period`  in  DIV_WIDTH  clock cycles per sample, minus one.
- `read_data`  in  10  memory output, registered by the memory, 1-cycle latency.
- `read_address`  out  7  memory address, registered.
- `read_state`  out  2  quadrant, registered.
- `sample`  out  10  captured sample.
- `sample_valid`  out  1  one-cycle strobe, `sample` is new.
- `sample_first`  out  1  qualifies `sample_valid`: sample is the first request of a PEAK quadrant.

## Operation
- Quadrant encoding: PEAK=0, FALL=1, TROUGH=2, RISE=3. The memory applies mirroring and negation; this block only counts.
- Sequence: in each quadrant, `read_address` counts 0..127.
  - On wrap 127→0, `read_state` advances PEAK→FALL→TROUGH→RISE→PEAK.
- Divider counter `tick_cnt`:
  - When `enable`=1: counts 0..`period`. If `tick_cnt` >= `period`, it returns to 0 and raises internal `tick`.
  - When `enable`=0: holds.
- On `tick`:
  - `read_address` increments (step 1, or `phase_step` if configured), modulo 128.
  - Carry out of the address advances `read_state`, modulo 4.
- Request pipeline:
  - `req_d1` = registered `tick`, marks the cycle in which the memory samples the new address.
  - `req_d2` = registered `req_d1`.
  - The cycle after `req_d1`, `sample` <= `read_data` and `sample_valid`=1.
  - `sample_first` is carried down the pipeline alongside the request. It is set when the new request has state PEAK and address < step (i.e. address 0 when step=1).
- `period` change mid-count: takes effect immediately. If `tick_cnt` >= the new `period`, a tick fires on the next enabled cycle.
- `enable` falling: requests already in flight still deliver their `sample_valid`. No new ticks are issued. Address and state are held.
- `enable` rising: counting resumes from the held `tick_cnt`.

## Timing
- Reset values (`rst_n`=0 at a rising edge):
  - `read_address`=0, `read_state`=PEAK, `tick_cnt`=0.
  - `sample`=0, `sample_valid`=0, `sample_first`=0.
  - Pipeline flags cleared.
- Reset mid-operation: in-flight samples are discarded; no strobe is issued after reset.
- After release, the first address (PEAK, 0) is presented at reset values. That address is not strobed. The first tick requests address 1.
- Latency: new address visible in cycle N → `sample_valid` high in cycle N+2 with the matching data.
- `period`=0: one request per cycle, fully pipelined. `sample_valid` stays high continuously.
- Full waveform: 512/step requests.
  - Output sample rate = f_clk/(`period`+1).
  - Waveform frequency = f_clk·step/(512·(`period`+1)).
- `sample_valid` is never asserted for more than one cycle per request.

## Configuration
- `SINE_SEQ_PHASE_STEP_EN` defined:
  - Adds input port `phase_step` [3:0] and uses it as the address increment, for frequency multiplication.
  - `read_address` = (`read_address` + `phase_step`) mod 128; the carry advances `read_state`.
  - `phase_step`=0 holds the address while still strobing samples.
  - `phase_step` is sampled on each tick.
- Undefined: no `phase_step` port; the step is a constant 1.

## Structure
- Package `sine_pkg`:
  - Quadrant constants PEAK/FALL/TROUGH/RISE, or a 2-bit enum `quadrant_t`.
  - `ADDR_W`=7, `DATA_W`=10.
  - Shared with the sample memory.
- Sub-module `tick_divider`:
  - Parameterised by `DIV_WIDTH`.
  - Inputs `clk`, `rst_n`, `enable`, `period`; output `tick`.
- Remaining logic is the address/quadrant counter plus the two-stage capture pipeline in `sine_sequencer`.

## Test plan
- Reset then `enable`=1, `period`=0, memory model returning {state,addr} packed:
  - `sample_valid` continuous from cycle 3.
  - Samples follow (PEAK,1)…(PEAK,127),(FALL,0)…(RISE,127),(PEAK,0).
  - `sample_first` is high only on (PEAK,0).
- `period`=3:
  - `read_address` changes every 4 cycles.
  - Each `sample_valid` arrives exactly 2 cycles after its address change.
  - 512 samples take 2048 cycles.
- `enable` dropped on the cycle after a tick:
  - That in-flight sample is still strobed 2 cycles later.
  - Address/state then stay frozen for 20 cycles.
  - After re-enable, counting resumes without a skip.
- `period` reduced from 100 to 5 while `tick_cnt`=50:
  - A tick fires on the next enabled cycle.
  - Subsequent ticks are spaced 6 cycles apart.
- `rst_n` pulsed low for one cycle with two requests in flight:
  - No `sample_valid` follows.
  - Outputs take their reset values on the next cycle.
- With `SINE_SEQ_PHASE_STEP_EN`, `phase_step`=5, from (PEAK,125):
  - Next request is (FALL,2) with `sample_first`=0.
  - From (RISE,126), the next request is (PEAK,3) with `sample_first`=1.
